// File: rtl/shiftreg_out_ctl.sv
// Serial driver for a chain of 74HC595-style latching shift registers: shifts a word out MSB first
// on a divided clock, then pulses the latch. Optional macro SHIFTREG_OUT_AUTO_REFRESH_EN adds idle auto-refresh.
module shiftreg_out_ctl #(
  parameter int WIDTH        = 16,
  parameter int CLK_DIV_BITS = 10
) (
  input  logic             clock_50m,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             done,
  output logic             shiftreg_clk,
  output logic             shiftreg_data,
  output logic             shiftreg_latch,
  output logic [WIDTH-1:0] shown
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t                  r_state;
  logic [CLK_DIV_BITS-1:0] r_div;
  logic [WIDTH-1:0]        r_shadow;
  logic [CW-1:0]           r_bit_cnt;
  logic                    r_phase;
  logic                    r_ready;
  logic                    r_done;
  logic                    r_sclk;
  logic                    r_sdata;
  logic                    r_latch;
  logic [WIDTH-1:0]        r_shown;

  state_t                  w_state_nxt;
  logic [WIDTH-1:0]        w_shadow_nxt;
  logic [CW-1:0]           w_bit_cnt_nxt;
  logic                    w_phase_nxt;
  logic                    w_ready_nxt;
  logic                    w_done_nxt;
  logic                    w_sclk_nxt;
  logic                    w_sdata_nxt;
  logic                    w_latch_nxt;
  logic [WIDTH-1:0]        w_shown_nxt;
  logic                    w_tick;

`ifdef SHIFTREG_OUT_AUTO_REFRESH_EN
  logic [15:0]             r_idle_cnt;
  logic                    r_refresh;
  logic [15:0]             w_idle_cnt_nxt;
  logic                    w_refresh_nxt;
`endif

  // Free-running divider; the handshake never restarts it, so the first tick may come up to a full period late.
  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + CLK_DIV_BITS'(1);
    end
  end

  assign w_tick = &r_div;

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_shadow  <= '0;
      r_bit_cnt <= '0;
      r_phase   <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_sdata   <= 1'b0;
      r_latch   <= 1'b0;
      r_shown   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shadow  <= w_shadow_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_ready   <= w_ready_nxt;
      r_done    <= w_done_nxt;
      r_sclk    <= w_sclk_nxt;
      r_sdata   <= w_sdata_nxt;
      r_latch   <= w_latch_nxt;
      r_shown   <= w_shown_nxt;
    end
  end

`ifdef SHIFTREG_OUT_AUTO_REFRESH_EN
  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= '0;
      r_refresh  <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_cnt_nxt;
      r_refresh  <= w_refresh_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_shadow_nxt  = r_shadow;
    w_bit_cnt_nxt = r_bit_cnt;
    w_phase_nxt   = r_phase;
    w_ready_nxt   = r_ready;
    w_done_nxt    = 1'b0;
    w_sclk_nxt    = r_sclk;
    w_sdata_nxt   = r_sdata;
    w_latch_nxt   = r_latch;
    w_shown_nxt   = r_shown;
`ifdef SHIFTREG_OUT_AUTO_REFRESH_EN
    w_idle_cnt_nxt = r_idle_cnt;
    w_refresh_nxt  = r_refresh;
`endif

    case (r_state)
      IDLE: begin
        w_ready_nxt = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_latch_nxt = 1'b0;
        if (data_valid && r_ready) begin
          w_shadow_nxt  = data_in;
          w_bit_cnt_nxt = LAST_BIT;
          w_phase_nxt   = 1'b0;
          w_ready_nxt   = 1'b0;
          w_state_nxt   = SHIFT;
`ifdef SHIFTREG_OUT_AUTO_REFRESH_EN
          w_idle_cnt_nxt = '0;
          w_refresh_nxt  = 1'b0;
`endif
        end
`ifdef SHIFTREG_OUT_AUTO_REFRESH_EN
        // Refresh fires on the tick that would bring the idle count to 0xFFFF.
        else if (w_tick) begin
          if (r_idle_cnt == 16'hFFFE) begin
            w_shadow_nxt   = r_shown;
            w_bit_cnt_nxt  = LAST_BIT;
            w_phase_nxt    = 1'b0;
            w_ready_nxt    = 1'b0;
            w_idle_cnt_nxt = '0;
            w_refresh_nxt  = 1'b1;
            w_state_nxt    = SHIFT;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + 16'd1;
          end
        end
`endif
      end

      SHIFT: begin
        if (w_tick) begin
          if (!r_phase) begin
            w_sclk_nxt  = 1'b0;
            w_sdata_nxt = r_shadow[r_bit_cnt];
            w_phase_nxt = 1'b1;
          end else begin
            w_sclk_nxt  = 1'b1;
            w_phase_nxt = 1'b0;
            if (r_bit_cnt == '0) begin
              w_state_nxt = LATCH;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt - CW'(1);
            end
          end
        end
      end

      LATCH: begin
        if (w_tick) begin
          if (!r_phase) begin
            w_sclk_nxt  = 1'b0;
            w_latch_nxt = 1'b1;
            w_phase_nxt = 1'b1;
          end else begin
            w_latch_nxt = 1'b0;
            w_phase_nxt = 1'b0;
            w_shown_nxt = r_shadow;
            w_ready_nxt = 1'b1;
            w_state_nxt = IDLE;
`ifdef SHIFTREG_OUT_AUTO_REFRESH_EN
            w_done_nxt    = !r_refresh;
            w_refresh_nxt = 1'b0;
`else
            w_done_nxt    = 1'b1;
`endif
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_latch_nxt = 1'b0;
        w_phase_nxt = 1'b0;
      end
    endcase
  end

  assign data_ready     = r_ready;
  assign done           = r_done;
  assign shiftreg_clk   = r_sclk;
  assign shiftreg_data  = r_sdata;
  assign shiftreg_latch = r_latch;
  assign shown          = r_shown;

endmodule
